mealy_seq_detector: RTL and testbench
=====================================

MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
REQ-001 Parameter SYM_W, default 2, symbol width in bits (1..8).
REQ-002 Parameter DEPTH, default 4, pattern length in symbols (2..16).
REQ-003 Parameter CNT_W, default 8, match counter width.
REQ-004 Parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-005 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port x_valid, input, 1, symbol on x is consumed this cycle.
REQ-008 Port x, input, SYM_W, input symbol.
REQ-009 Port pat_load, input, 1, load pattern from pat_in this cycle.
REQ-010 Port pat_in, input, SYM_W*DEPTH, pattern; symbol i at bits [i*SYM_W +: SYM_W], symbol 0 is first received.
REQ-011 Port cnt_clr, input, 1, synchronous clear of match_cnt.
REQ-012 Port out, output, 1, Mealy match flag, combinational from state and x/x_valid.
REQ-013 Port out_q, output, 1, out registered one cycle.
REQ-014 Port armed, output, 1, history full (fill == DEPTH-1).
REQ-015 Port match_cnt, output, CNT_W, saturating count of matches.

Function
REQ-016 Block SHALL hold a pattern register (DEPTH symbols), a history register (DEPTH-1 symbols, newest last) and a fill counter 0..DEPTH-1 as its state.
REQ-017 Fill counter SHALL act as FSM state: S_k = k symbols of history valid; S_(DEPTH-1) = ARMED.
REQ-018 out SHALL be 1 iff x_valid=1, pat_load=0, fill=DEPTH-1, history equals pattern symbols 0..DEPTH-2, and x equals pattern symbol DEPTH-1; else 0.
REQ-019 On x_valid=1 and pat_load=0, x SHALL shift into history and fill SHALL advance S_k -> S_(k+1), saturating at S_(DEPTH-1).
REQ-020 With OVERLAP=0, a cycle with out=1 SHALL instead set fill to S_0 (history contents don't-care).
REQ-021 With OVERLAP=1, a match SHALL not alter fill; the next match may share symbols.
REQ-022 x_valid=0 SHALL hold history, fill and pattern unchanged; idle gaps do not break a sequence.
REQ-023 pat_load=1 SHALL load pat_in into the pattern register and set fill to S_0; if x_valid=1 the same cycle, x SHALL be discarded and out SHALL be 0.
REQ-024 match_cnt SHALL increment by 1 on each cycle with out=1 and saturate at 2^CNT_W-1 (no wrap).
REQ-025 cnt_clr=1 SHALL set match_cnt to 0 on the next edge; simultaneous cnt_clr and out=1 SHALL yield 0.
REQ-026 out_q SHALL equal out of the previous cycle.
REQ-027 armed SHALL be 1 iff fill = DEPTH-1.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk, set pattern to all zeros, history to zeros, fill to S_0, match_cnt to 0, out_q to 0; armed reads 0 and out reads 0 while in S_0.
REQ-029 rst asserted mid-sequence SHALL discard partial matches; the first match after release requires DEPTH fresh valid symbols.
REQ-030 Release of rst SHALL take effect at the first rising clk edge after deassertion, with no spurious out or count.

Verification
REQ-031 Defaults, load pattern {1,2,3,0}, stream 1,2,3,0 valid every cycle -> out=1 only on 4th symbol, out_q=1 next cycle, match_cnt=1.
REQ-032 Pattern {1,1,1,1}, six valid 1s, OVERLAP=1 -> out on symbols 4,5,6, match_cnt=3; OVERLAP=0 -> out on symbol 4 only, match_cnt=1.
REQ-033 Stream 1,2,<x_valid=0 for 3 cycles>,3,0 -> match on 0, match_cnt=1; stream 1,2,2,3,0 -> no match.
REQ-034 pat_load with x_valid=1 on what would be the matching symbol -> out=0, fill=0, armed=0, new pattern active next cycle.
REQ-035 CNT_W=2, five matches -> match_cnt=3 held; cnt_clr coincident with a match -> match_cnt=0.
REQ-036 rst pulse between clk edges after 3 of 4 pattern symbols -> fill=0, match_cnt=0 immediately; 4th symbol after release gives no match.

Source files
------------

// File: rtl/mealy_seq_detector.sv
// ---------------------------------------------------------------------------
// mealy_seq_detector
//
// Watches a stream of SYM_W-bit symbols and flags, in the same cycle as the
// last symbol arrives, when the most recent DEPTH valid symbols equal a
// loadable pattern. The flag is a Mealy output: it is combinational from the
// stored history/fill state and the current x/x_valid.
//
// Handshake: x is consumed on every rising edge where x_valid=1 and
// pat_load=0. There is no back-pressure. Cycles with x_valid=0 leave all
// sequence state untouched.
//
// State:
//   pat_r   DEPTH symbols, symbol 0 is the first one expected
//   hist_r  DEPTH-1 most recent consumed symbols, newest at the top index
//   fill    number of valid history symbols (0..DEPTH-1); this counter is
//           the FSM state, fill == DEPTH-1 is the ARMED state
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   x_valid    x is consumed this cycle
//   x          input symbol
//   pat_load   load pat_in into the pattern register, restart the sequence
//   pat_in     pattern, symbol i at bits [i*SYM_W +: SYM_W]
//   cnt_clr    synchronous clear of match_cnt (wins over an increment)
//   out        combinational match flag
//   out_q      out delayed by one cycle
//   armed      history is full (fill == DEPTH-1)
//   match_cnt  saturating count of matches
// ---------------------------------------------------------------------------
module mealy_seq_detector #(
    parameter int SYM_W   = 2,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     x_valid,
    input  logic [SYM_W-1:0]         x,
    input  logic                     pat_load,
    input  logic [SYM_W*DEPTH-1:0]   pat_in,
    input  logic                     cnt_clr,
    output logic                     out,
    output logic                     out_q,
    output logic                     armed,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int                FILL_W   = $clog2(DEPTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // Coarse view of the fill-counter FSM: still collecting history, or
    // armed and able to match on the next valid symbol.
    typedef enum logic {
        PH_FILLING = 1'b0,
        PH_ARMED   = 1'b1
    } phase_t;

    logic [SYM_W-1:0]  pat_r   [DEPTH];
    logic [SYM_W-1:0]  pat_nx  [DEPTH];
    logic [SYM_W-1:0]  hist_r  [DEPTH-1];
    logic [SYM_W-1:0]  hist_nx [DEPTH-1];
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic              prefix_eq;
    phase_t            phase;

    assign phase = (fill == FILL_MAX) ? PH_ARMED : PH_FILLING;
    assign armed = (phase == PH_ARMED);

    // History must equal pattern symbols 0..DEPTH-2; the final pattern
    // symbol is compared against the live input instead.
    always_comb begin
        prefix_eq = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (hist_r[i] != pat_r[i]) begin
                prefix_eq = 1'b0;
            end
        end
    end

    // A pattern load in the same cycle discards x, so it also masks out.
    assign out = x_valid && !pat_load && armed && prefix_eq &&
                 (x == pat_r[DEPTH-1]);

    // Next-state logic for pattern, history, fill and counter.
    always_comb begin
        pat_nx  = pat_r;
        hist_nx = hist_r;
        fill_nx = fill;
        cnt_nx  = match_cnt;

        if (pat_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat_nx[i] = pat_in[i*SYM_W +: SYM_W];
            end
            fill_nx = '0;
        end else if (x_valid) begin
            for (int i = 0; i < DEPTH - 2; i++) begin
                hist_nx[i] = hist_r[i+1];
            end
            hist_nx[DEPTH-2] = x;
            // Non-overlapping mode restarts collection after a match; the
            // shifted history is then stale but unused until refilled.
            if (out && (OVERLAP == 0)) begin
                fill_nx = '0;
            end else if (phase == PH_FILLING) begin
                fill_nx = fill + FILL_W'(1);
            end
        end

        if (cnt_clr) begin
            cnt_nx = '0;
        end else if (out && (match_cnt != CNT_MAX)) begin
            cnt_nx = match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat_r[i] <= '0;
            end
            for (int i = 0; i < DEPTH - 1; i++) begin
                hist_r[i] <= '0;
            end
            fill      <= '0;
            match_cnt <= '0;
            out_q     <= 1'b0;
        end else begin
            pat_r     <= pat_nx;
            hist_r    <= hist_nx;
            fill      <= fill_nx;
            match_cnt <= cnt_nx;
            out_q     <= out;
        end
    end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_mealy_seq_detector
//
// Three detector instances share one stimulus stream:
//   d0: defaults (overlapping, 8-bit counter)
//   d1: OVERLAP=0
//   d2: CNT_W=2 (saturates at 3)
// Expected Mealy outputs are computed from a behavioural model when each
// symbol is driven, queued, and compared once the combinational output has
// settled. Registered outputs are compared after the following rising edge.
// ---------------------------------------------------------------------------
module tb_mealy_seq_detector;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       x_valid;
    logic [1:0] x;
    logic       pat_load;
    logic [7:0] pat_in;
    logic       cnt_clr;

    logic       o0, o1, o2;
    logic       oq0, oq1, oq2;
    logic       ar0, ar1, ar2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    mealy_seq_detector dut0 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out(o0), .out_q(oq0),
        .armed(ar0), .match_cnt(cnt0)
    );

    mealy_seq_detector #(.OVERLAP(0)) dut1 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out(o1), .out_q(oq1),
        .armed(ar1), .match_cnt(cnt1)
    );

    mealy_seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out(o2), .out_q(oq2),
        .armed(ar2), .match_cnt(cnt2)
    );

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pat  [3][4];
    int m_hist [3][3];   // oldest at [0], newest at [2]
    int m_fill [3];
    int m_cnt  [3];
    bit m_outq [3];
    int m_ovl  [3] = '{1, 0, 1};
    int m_cmax [3] = '{255, 255, 3};

    logic [2:0] exp_q[$];

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) m_pat[c][i] = 0;
            for (int i = 0; i < 3; i++) m_hist[c][i] = 0;
            m_fill[c] = 0;
            m_cnt[c]  = 0;
            m_outq[c] = 1'b0;
        end
    endtask

    function automatic bit m_out(int c, bit v, int xs, bit ld);
        if (!v || ld || m_fill[c] != 3) return 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m_hist[c][i] != m_pat[c][i]) return 1'b0;
        end
        return (xs == m_pat[c][3]);
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive at the falling edge, check out mid-cycle, advance the
    // model on the rising edge and check registered outputs just after it.
    task automatic step(input bit v, input int xs, input bit ld = 1'b0,
                        input logic [7:0] pat = 8'h00, input bit clr = 1'b0);
        logic [2:0] e;
        logic [2:0] exp_oq;
        logic [2:0] exp_ar;
        logic [1:0] psym;
        @(negedge clk);
        x_valid  = v;
        x        = xs[1:0];
        pat_load = ld;
        pat_in   = pat;
        cnt_clr  = clr;
        for (int c = 0; c < 3; c++) e[c] = m_out(c, v, xs, ld);
        exp_q.push_back(e);
        #1;
        check("out", {o2, o1, o0}, exp_q.pop_front());

        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (clr) m_cnt[c] = 0;
            else if (e[c] && m_cnt[c] < m_cmax[c]) m_cnt[c]++;
            m_outq[c] = e[c];
            if (ld) begin
                for (int i = 0; i < 4; i++) begin
                    psym = pat[i*2 +: 2];
                    m_pat[c][i] = int'(psym);
                end
                m_fill[c] = 0;
            end else if (v) begin
                m_hist[c][0] = m_hist[c][1];
                m_hist[c][1] = m_hist[c][2];
                m_hist[c][2] = xs;
                if (e[c] && m_ovl[c] == 0) m_fill[c] = 0;
                else if (m_fill[c] < 3) m_fill[c]++;
            end
            exp_oq[c] = m_outq[c];
            exp_ar[c] = (m_fill[c] == 3);
        end
        #1;
        check("out_q", {oq2, oq1, oq0}, exp_oq);
        check("armed", {ar2, ar1, ar0}, exp_ar);
        check("cnt0", cnt0, m_cnt[0]);
        check("cnt1", cnt1, m_cnt[1]);
        check("cnt2", cnt2, m_cnt[2]);
    endtask

    localparam logic [7:0] PAT_1230 = 8'b00_11_10_01;
    localparam logic [7:0] PAT_1111 = 8'b01_01_01_01;
    localparam logic [7:0] PAT_0000 = 8'b00_00_00_00;

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        x_valid = 1'b0; x = '0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",   {o2, o1, o0}, 3'b000);
        check("rst_out_q", {oq2, oq1, oq0}, 3'b000);
        check("rst_armed", {ar2, ar1, ar0}, 3'b000);
        check("rst_cnt0",  cnt0, 0);
        check("rst_fill",  dut0.fill, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic match: pattern {1,2,3,0}
        step(0, 0, 1, PAT_1230);
        step(1, 1); step(1, 2); step(1, 3); step(1, 0);
        check("basic_out_q", oq0, 1'b1);
        step(0, 0);
        check("basic_cnt", cnt0, 1);

        // Idle gaps inside a sequence, then a broken sequence
        step(0, 0, 0, PAT_0000, 1);
        step(1, 1); step(1, 2);
        repeat (3) step(0, 0);
        step(1, 3); step(1, 0);
        check("gap_cnt", cnt0, 1);
        step(1, 1); step(1, 2); step(1, 2); step(1, 3); step(1, 0);
        check("broken_cnt", cnt0, 1);

        // Overlap vs non-overlap: pattern {1,1,1,1}, six 1s
        step(0, 0, 1, PAT_1111, 1);
        repeat (6) step(1, 1);
        check("ovl_cnt0", cnt0, 3);
        check("novl_cnt1", cnt1, 1);
        check("ovl_cnt2", cnt2, 3);

        // Saturation and clear coincident with a match
        step(0, 0, 1, PAT_1111, 1);
        repeat (8) step(1, 1);
        check("sat_cnt0", cnt0, 5);
        check("sat_cnt1", cnt1, 2);
        check("sat_cnt2", cnt2, 3);
        step(1, 1, 0, PAT_0000, 1);
        check("clr_vs_match_cnt0", cnt0, 0);
        check("clr_vs_match_cnt2", cnt2, 0);

        // Pattern load on what would be the matching symbol
        step(0, 0, 1, PAT_1230, 1);
        step(1, 1); step(1, 2); step(1, 3);
        check("pre_load_armed", ar0, 1'b1);
        step(1, 0, 1, PAT_0000);
        check("load_fill", dut0.fill, 0);
        check("load_armed", ar0, 1'b0);
        check("load_cnt", cnt0, 0);
        repeat (4) step(1, 0);
        check("newpat_cnt", cnt0, 1);

        // Asynchronous reset between edges after 3 of 4 symbols
        step(0, 0, 1, PAT_1230, 1);
        step(1, 1); step(1, 2); step(1, 3); step(1, 0);
        step(1, 1); step(1, 2); step(1, 3);
        check("pre_rst_cnt", cnt0, 1);
        #1 rst = 1'b1;
        #1;
        check("async_cnt0", cnt0, 0);
        check("async_fill", dut0.fill, 0);
        check("async_armed", {ar2, ar1, ar0}, 3'b000);
        check("async_out_q", {oq2, oq1, oq0}, 3'b000);
        #1 rst = 1'b0;
        model_reset();
        step(1, 0);
        check("post_rst_cnt", cnt0, 0);
        step(0, 0);

        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1);
    end

endmodule
